// File: rtl/clkdiv_sched.sv
// ============================================================================
//  Module   : clkdiv_sched
//  Purpose  : Run-time programmable clock divider with glitch-free divisor
//             switching, start/stop control and a once-per-period tick.
//  Option   : CLKDIV_SCHED_PERIOD_CNT_EN adds a 16-bit completed-period count.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkdiv_sched #(
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] cur_div,
    output logic             running
`ifdef CLKDIV_SCHED_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] C_MIN_DIV = CNT_W'(2);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             ready_q, ready_d;
    logic             running_q, running_d;

    logic             w_xfer;
    logic             w_wrap;
    logic [CNT_W-1:0] w_div_clamped;

    assign w_xfer        = div_valid && ready_q;
    assign w_wrap        = (cnt_q == (cur_div_q - C_ONE));
    assign w_div_clamped = (div_in < C_MIN_DIV) ? C_MIN_DIV : div_in;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        cur_div_d = cur_div_q;
        tick_d    = (state_q != ST_STOP) && w_wrap;

        case (state_q)
            ST_STOP: begin
                cnt_d = '0;
                if (w_xfer) begin
                    cur_div_d = w_div_clamped;
                end
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = w_wrap ? '0 : (cnt_q + C_ONE);
                if (w_wrap && !en) begin
                    // Stopping at this boundary: nothing left to switch, so
                    // a divisor arriving on the same edge is applied directly.
                    state_d = ST_STOP;
                    if (w_xfer) begin
                        cur_div_d = w_div_clamped;
                    end
                end else if (w_xfer) begin
                    pend_d  = w_div_clamped;
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                cnt_d = w_wrap ? '0 : (cnt_q + C_ONE);
                if (w_wrap) begin
                    cur_div_d = pend_q;
                    state_d   = en ? ST_RUN : ST_STOP;
                end
            end
            default: begin
                state_d = ST_STOP;
                cnt_d   = '0;
            end
        endcase

        running_d = (state_d != ST_STOP);
        ready_d   = (state_d != ST_SWITCH);
        // Registered from the next count and next divisor so clk_out lines up
        // with the counter and a new divisor starts with a clean high phase.
        clk_out_d = running_d && (cnt_d < (cur_div_d >> 1));
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_STOP;
            cnt_q     <= '0;
            pend_q    <= '0;
            cur_div_q <= C_DEF_DIV;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            ready_q   <= 1'b1;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            cur_div_q <= cur_div_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            ready_q   <= ready_d;
            running_q <= running_d;
        end
    end

    assign div_ready = ready_q;
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign cur_div   = cur_div_q;
    assign running   = running_q;

`ifdef CLKDIV_SCHED_PERIOD_CNT_EN
    logic [15:0] pcnt_q, pcnt_d;
    logic        w_div_load;

    assign w_div_load = ((state_q == ST_STOP) && w_xfer)
                     || ((state_q == ST_SWITCH) && w_wrap)
                     || ((state_q == ST_RUN) && w_wrap && !en && w_xfer);

    always_comb begin
        pcnt_d = pcnt_q;
        if (w_div_load) begin
            pcnt_d = '0;
        end else if (tick_d) begin
            pcnt_d = pcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign period_cnt = pcnt_q;
`endif

endmodule

`default_nettype wire
